// File: rtl/clk_pulse_gate.sv
// clk_pulse_gate: processor clock-enable gate with free-run, halt and N-cycle bursts.
// Optional macro CLK_PULSE_CYCLE_COUNT_EN adds a 32-bit enabled-cycle counter output.
module clk_pulse_gate #(
    parameter int PULSE_BITS = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  write_pulse,
    input  logic [PULSE_BITS-1:0] num_pulses,
    output logic                  proc_clk_en,
    output logic                  busy,
    output logic [PULSE_BITS-1:0] pulses_remaining,
    output logic                  pulse_done
`ifdef CLK_PULSE_CYCLE_COUNT_EN
   ,output logic [31:0]           cycle_count
`endif
);

    typedef enum logic [1:0] {
        S_HALTED   = 2'd0,
        S_FREE_RUN = 2'd1,
        S_PULSING  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_proc_clk_en;
    logic                  r_busy;
    logic [PULSE_BITS-1:0] r_rem;
    logic                  r_done;

    state_t                w_state_nxt;
    logic                  w_en_nxt;
    logic                  w_busy_nxt;
    logic [PULSE_BITS-1:0] w_rem_nxt;
    logic                  w_done_nxt;
    logic                  w_last;
    logic                  w_load;

    // The burst ends on the edge that closes the cycle where one pulse is left.
    assign w_last = (r_rem == PULSE_BITS'(1));
    assign w_load = (num_pulses != '0);

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        w_rem_nxt   = r_rem;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_HALTED: begin
                if (write_pulse) begin
                    if (w_load) begin
                        w_state_nxt = S_PULSING;
                        w_en_nxt    = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_rem_nxt   = num_pulses;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end else if (clk_enable) begin
                    w_state_nxt = S_FREE_RUN;
                    w_en_nxt    = 1'b1;
                end
            end
            S_FREE_RUN: begin
                if (clk_enable) begin
                    w_en_nxt    = 1'b1;
                end else begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_PULSING: begin
                w_rem_nxt = r_rem - PULSE_BITS'(1);
                if (w_last) begin
                    // Gap cycle: enable stays low even when resuming free-run.
                    w_done_nxt  = 1'b1;
                    w_state_nxt = clk_enable ? S_FREE_RUN : S_HALTED;
                end else begin
                    w_en_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_HALTED;
                w_rem_nxt   = '0;
            end
        endcase
    end

    // State register; reset aborts any burst without a completion strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_HALTED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_proc_clk_en <= 1'b0;
            r_busy        <= 1'b0;
            r_rem         <= '0;
            r_done        <= 1'b0;
        end else begin
            r_proc_clk_en <= w_en_nxt;
            r_busy        <= w_busy_nxt;
            r_rem         <= w_rem_nxt;
            r_done        <= w_done_nxt;
        end
    end

    assign proc_clk_en      = r_proc_clk_en;
    assign busy             = r_busy;
    assign pulses_remaining = r_rem;
    assign pulse_done       = r_done;

`ifdef CLK_PULSE_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    // Counts every cycle the processor advances; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_count <= 32'd0;
        end else if (r_proc_clk_en) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

endmodule

// File: doc/clk_pulse_gate.md
CLK_PULSE_GATE -- requirements
Module: clk_pulse_gate

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, clocking on the rising edge of clk.
REQ-002 The block SHALL have parameter PULSE_BITS, default 12: width of the pulse-count field.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  asynchronous active-low reset; 0 = in reset.
REQ-005 clk_enable  input  1  level; 1 = processor free-runs, 0 = processor halted.
REQ-006 write_pulse  input  1  single-cycle strobe; requests a burst of num_pulses processor cycles.
REQ-007 num_pulses  input  PULSE_BITS  burst length; sampled only in the cycle write_pulse=1.
REQ-008 proc_clk_en  output  1  registered clock enable to the processor; 1 = processor advances this cycle.
REQ-009 busy  output  1  1 while a burst is in progress.
REQ-010 pulses_remaining  output  PULSE_BITS  processor cycles left in the current burst.
REQ-011 pulse_done  output  1  single-cycle strobe marking burst completion.

Function
REQ-012 The block SHALL implement the states HALTED, FREE_RUN and PULSING.
REQ-013 HALTED: proc_clk_en=0; goes to FREE_RUN at the next edge when clk_enable=1.
REQ-014 FREE_RUN: proc_clk_en=1 every cycle; goes to HALTED at the next edge when clk_enable=0.
REQ-015 HALTED with write_pulse=1 and num_pulses=N>0: at the next edge, load pulses_remaining=N, set busy=1 and enter PULSING.
REQ-016 PULSING: proc_clk_en=1 for exactly N consecutive cycles, starting the cycle after the write_pulse strobe.
REQ-017 PULSING: pulses_remaining SHALL decrement by 1 on each cycle with proc_clk_en=1 and reach 0 on the edge that ends the last enabled cycle.
REQ-018 At the end of a burst, the cycle after the last enabled cycle SHALL have proc_clk_en=0, busy=0 and pulse_done=1 for exactly one cycle.
REQ-019 At the end of a burst, the next state SHALL be FREE_RUN if clk_enable=1 at that edge, otherwise HALTED.
REQ-020 HALTED with write_pulse=1 and num_pulses=0: state SHALL stay HALTED, with no enabled cycle, and pulse_done=1 for one cycle the following cycle.
REQ-021 write_pulse SHALL be ignored in FREE_RUN and PULSING: no reload, no pulse_done.
REQ-022 A change of clk_enable during PULSING SHALL NOT shorten or extend the burst; it is evaluated only at burst end.
REQ-023 In HALTED with clk_enable=1 and write_pulse=1 in the same cycle, write_pulse SHALL win: the block enters PULSING.
REQ-024 N=2^PULSE_BITS-1 SHALL be supported with no wrap-around of pulses_remaining.
REQ-025 All outputs SHALL be registered; there is no combinational path from input to output.

Reset
REQ-026 reset=0 SHALL force asynchronously: state=HALTED, proc_clk_en=0, busy=0, pulses_remaining=0, pulse_done=0.
REQ-027 Reset asserted mid-burst SHALL abort the burst without generating pulse_done.
REQ-028 After reset deasserts, the first edge SHALL sample clk_enable and write_pulse as in HALTED.

Configuration
REQ-029 The block SHALL support the macro CLK_PULSE_CYCLE_COUNT_EN.
REQ-030 With CLK_PULSE_CYCLE_COUNT_EN defined, the block SHALL add output cycle_count [31:0].
REQ-031 cycle_count SHALL increment on every cycle with proc_clk_en=1.
REQ-032 cycle_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-033 cycle_count SHALL clear to 0 on reset.
REQ-034 Without CLK_PULSE_CYCLE_COUNT_EN, the cycle_count port and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-035 Reset, hold clk_enable=0, strobe write_pulse with num_pulses=3 -> proc_clk_en=1 for exactly 3 cycles starting the next cycle; pulses_remaining shows 3,2,1,0; pulse_done=1 the cycle after; busy=0.
REQ-036 HALTED, num_pulses=0 with strobe -> no proc_clk_en, pulse_done=1 one cycle later, state stays HALTED.
REQ-037 Burst of 5; raise clk_enable at pulse 2 -> still exactly 5 burst cycles, pulse_done, then proc_clk_en=1 continuously (FREE_RUN).
REQ-038 FREE_RUN, strobe write_pulse with num_pulses=7 -> proc_clk_en stays 1, busy=0, no pulse_done; drop clk_enable -> proc_clk_en=0 one cycle later.
REQ-039 Burst of 4095 with reset=0 asserted at pulse 100 -> all outputs 0 immediately, no pulse_done; after release with clk_enable=0 -> HALTED.
REQ-040 With CLK_PULSE_CYCLE_COUNT_EN defined: 10 free-run cycles plus a burst of 3 -> cycle_count=13; reset -> cycle_count=0.
